// File: rtl/rgb_pwm_sequencer.sv
// rgb_pwm_sequencer
// RGB status-LED driver. It steps through NUM_STEPS colours at a programmable
// dwell rate and adds PWM brightness, a breathe (fade) mode, a fixed-colour
// hold mode, an off mode and a pause input. LED pins are active-low and
// registered.
module rgb_pwm_sequencer #(
    parameter int PWM_W     = 8,
    parameter int DWELL_W   = 24,
    parameter int NUM_STEPS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [PWM_W-1:0]   brightness,
    input  logic [2:0]         color_sel,
    input  logic               pause,
    output logic               red_led,
    output logic               green_led,
    output logic               blue_led,
    output logic [2:0]         step,
    output logic               step_pulse
);

    localparam logic [1:0] MODE_STEP = 2'd0;
    localparam logic [1:0] MODE_FADE = 2'd1;
    localparam logic [1:0] MODE_HOLD = 2'd2;
    localparam logic [1:0] MODE_OFF  = 2'd3;

    localparam logic [2:0]         LAST_STEP = 3'(NUM_STEPS - 1);
    localparam logic [PWM_W-1:0]   PWM_ZERO  = {PWM_W{1'b0}};
    localparam logic [PWM_W-1:0]   PWM_ONE   = {{(PWM_W-1){1'b0}}, 1'b1};
    localparam logic [DWELL_W-1:0] DWELL_ZERO = {DWELL_W{1'b0}};
    localparam logic [DWELL_W-1:0] DWELL_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        FADE_UP   = 1'b0,
        FADE_DOWN = 1'b1
    } fade_st_t;

    logic [PWM_W-1:0]   pwm_cnt_r;
    logic [1:0]         mode_q_r;
    logic [DWELL_W-1:0] dwell_cnt_r;
    logic [DWELL_W-1:0] dwell_q_r;
    logic [PWM_W-1:0]   level_r;
    fade_st_t           fade_st_r;
    logic [2:0]         step_r;
    logic               step_pulse_r;
    logic               red_led_r;
    logic               green_led_r;
    logic               blue_led_r;

    logic               mode_chg_s;
    logic               tick_s;
    fade_st_t           fade_nxt_s;
    logic [PWM_W-1:0]   level_nxt_s;
    logic               fade_adv_s;
    logic               advance_s;
    logic [2:0]         colour_s;
    logic [PWM_W-1:0]   duty_s;
    logic [2:0]         step_nxt_s;

    assign mode_chg_s = (mode != mode_q_r);
    // A tick is the last cycle of a dwell period; pause freezes the timer.
    assign tick_s     = (~pause) & (dwell_cnt_r == dwell_q_r);
    assign step_nxt_s = (step_r == LAST_STEP) ? 3'd0 : (step_r + 3'd1);

    // Free-running PWM counter; it ignores pause and mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_r <= PWM_ZERO;
        end else begin
            pwm_cnt_r <= pwm_cnt_r + PWM_ONE;
        end
    end

    // Mode register and dwell timer; a mode change restarts the dwell period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q_r    <= MODE_STEP;
            dwell_cnt_r <= DWELL_ZERO;
            dwell_q_r   <= DWELL_ZERO;
        end else if (mode_chg_s) begin
            mode_q_r    <= mode;
            dwell_cnt_r <= DWELL_ZERO;
            dwell_q_r   <= dwell;
        end else if (pause) begin
            mode_q_r    <= mode_q_r;
            dwell_cnt_r <= dwell_cnt_r;
            dwell_q_r   <= dwell_q_r;
        end else if (tick_s) begin
            mode_q_r    <= mode_q_r;
            dwell_cnt_r <= DWELL_ZERO;
            dwell_q_r   <= dwell;
        end else begin
            mode_q_r    <= mode_q_r;
            dwell_cnt_r <= dwell_cnt_r + DWELL_ONE;
            dwell_q_r   <= dwell_q_r;
        end
    end

    // Fade FSM state and level registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fade_st_r <= FADE_UP;
            level_r   <= PWM_ZERO;
        end else begin
            fade_st_r <= fade_nxt_s;
            level_r   <= level_nxt_s;
        end
    end

    // Fade FSM next state: ramp up to the live brightness, back down to zero, then advance.
    always_comb begin
        fade_nxt_s  = fade_st_r;
        level_nxt_s = level_r;
        fade_adv_s  = 1'b0;
        if (mode_chg_s) begin
            fade_nxt_s  = FADE_UP;
            level_nxt_s = PWM_ZERO;
        end else if ((mode_q_r == MODE_FADE) && tick_s) begin
            case (fade_st_r)
                FADE_UP: begin
                    if (level_r < brightness) begin
                        level_nxt_s = level_r + PWM_ONE;
                    end else begin
                        fade_nxt_s = FADE_DOWN;
                    end
                end
                FADE_DOWN: begin
                    if (level_r > PWM_ZERO) begin
                        level_nxt_s = level_r - PWM_ONE;
                    end else begin
                        fade_adv_s = 1'b1;
                        fade_nxt_s = FADE_UP;
                    end
                end
                default: begin
                    fade_nxt_s = FADE_UP;
                end
            endcase
        end else begin
            fade_nxt_s  = fade_st_r;
            level_nxt_s = level_r;
        end
    end

    // Per-mode outputs: step advance, displayed colour and PWM duty.
    always_comb begin
        advance_s = 1'b0;
        colour_s  = 3'b000;
        duty_s    = PWM_ZERO;
        if (mode_chg_s) begin
            advance_s = 1'b0;
        end else if ((mode_q_r == MODE_STEP) && tick_s) begin
            advance_s = 1'b1;
        end else begin
            advance_s = fade_adv_s;
        end
        case (mode_q_r)
            MODE_STEP: begin
                colour_s = step_r;
                duty_s   = brightness;
            end
            MODE_FADE: begin
                colour_s = step_r;
                duty_s   = level_r;
            end
            MODE_HOLD: begin
                colour_s = color_sel;
                duty_s   = brightness;
            end
            MODE_OFF: begin
                colour_s = 3'b000;
                duty_s   = PWM_ZERO;
            end
            default: begin
                colour_s = 3'b000;
                duty_s   = PWM_ZERO;
            end
        endcase
    end

    // Step index and its advance strobe; the strobe lines up with the new index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_r       <= 3'd0;
            step_pulse_r <= 1'b0;
        end else if (advance_s) begin
            step_r       <= step_nxt_s;
            step_pulse_r <= 1'b1;
        end else begin
            step_r       <= step_r;
            step_pulse_r <= 1'b0;
        end
    end

    // Registered active-low LED drives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            red_led_r   <= 1'b1;
            green_led_r <= 1'b1;
            blue_led_r  <= 1'b1;
        end else begin
            red_led_r   <= ~(colour_s[2] & (pwm_cnt_r < duty_s));
            green_led_r <= ~(colour_s[1] & (pwm_cnt_r < duty_s));
            blue_led_r  <= ~(colour_s[0] & (pwm_cnt_r < duty_s));
        end
    end

    assign red_led    = red_led_r;
    assign green_led  = green_led_r;
    assign blue_led   = blue_led_r;
    assign step       = step_r;
    assign step_pulse = step_pulse_r;

endmodule

// File: doc/rgb_pwm_sequencer.md
# rgb_pwm_sequencer

Parametrised RGB status-LED driver: steps through a configurable number of colour steps with programmable dwell, and adds PWM brightness control, a fade (breathe) mode, a fixed-colour hold mode, an off mode and a pause input. It sits between the board clock and the active-low RGB LED pins, replacing the fixed counter-plus-decoder colour cycler.

## Interface
- `PWM_W`, 8: PWM counter, brightness and fade-level width.
- `DWELL_W`, 24: dwell counter width.
- `NUM_STEPS`, 8: colour steps per sequence, legal 2..8.

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mode` in 2: 0 STEP, 1 FADE, 2 HOLD, 3 OFF.
- `dwell` in DWELL_W: tick period minus one, in cycles.
- `brightness` in PWM_W: maximum duty B.
- `color_sel` in 3: HOLD colour {R,G,B}.
- `pause` in 1: freezes sequencing while high.
- `red_led`, `green_led`, `blue_led` out 1: active-low LED drives (0 = lit).
- `step` out 3: current step index, 0..NUM_STEPS-1.
- `step_pulse` out 1: one-cycle strobe on step advance.

## Operation
- **Colour of step k:** k[2]=R, k[1]=G, k[0]=B. Step 0 is dark.
- **PWM:**
  - `pwm_cnt` is a free-running PWM_W counter that wraps 2^PWM_W-1 -> 0. It runs during pause and in every mode.
  - A channel is lit iff its colour bit is 1 and `pwm_cnt < duty`.
  - duty=0 gives never lit; the maximum is (2^PWM_W-1)/2^PWM_W.
- **Tick:**
  - The dwell counter counts 0..dwell_q. The cycle in which it equals dwell_q is a tick, and the counter returns to 0.
  - `dwell_q` is loaded from `dwell` on each tick and on each mode change, so a tick occurs every dwell_q+1 cycles. dwell=0 gives a tick every cycle.
- **STEP mode:**
  - duty = `brightness`.
  - Each tick advances `step`.
- **FADE mode:**
  - duty = `level`.
  - Two-state FSM, UP/DOWN, evaluated on each tick:
    - UP: if level < B then level+1, else go to DOWN (level unchanged).
    - DOWN: if level > 0 then level-1, else advance `step` and go to UP.
  - B is sampled live. If B falls below level during UP, the FSM goes to DOWN on the next tick.
- **HOLD mode:**
  - Colour = `color_sel`, duty = `brightness`.
  - `step` is held; no ticks advance anything.
- **OFF mode:** all LED outputs are 1.
- **Advance:** step <= (step == NUM_STEPS-1) ? 0 : step+1. `step_pulse` is high in the same cycle the new `step` value appears.
- **Pause:**
  - Dwell counter, `step`, `level` and FSM state are frozen.
  - `step_pulse` is 0 while paused.
  - PWM output continues at the frozen duty.
- **Mode change** (registered `mode_q` differs from `mode`), on the next edge:
  - `mode_q` updated, dwell counter cleared, `dwell_q` reloaded, `level` cleared, FSM to UP.
  - `step` is retained.
  - Mode change takes priority over a coincident tick.
- **Reset:**
  - LED outputs 1, `step` 0, `step_pulse` 0, `pwm_cnt` 0, dwell counter 0, `dwell_q` 0, `level` 0, FSM UP, `mode_q` 0.
  - Reset mid-sequence restarts from this state immediately.

## Timing
- LED outputs are registered. They reflect `pwm_cnt`, duty and colour from the previous cycle, a latency of 1 cycle.
- STEP: `step` changes every dwell+1 cycles. The first advance occurs 1 cycle after reset release, because `dwell_q`=0 at reset.
- FADE: one step takes (2B+2) ticks, which is (2B+2)(dwell+1) cycles. B=0 gives 2 ticks per step.
- `dwell`, `brightness` and `color_sel` are not required to be stable. `dwell` takes effect at the next tick boundary; `brightness` and `color_sel` take effect 1 cycle after they change.
- Arithmetic:
  - `level` never exceeds 2^PWM_W-1 and never wraps below 0.
  - The dwell comparison is exact equality at DWELL_W.

## Test plan
- Reset, then STEP with dwell=3, B=255 (PWM_W=8, NUM_STEPS=8) -> `step` 0,1,..,7,0 changes every 4 cycles; `step_pulse` one cycle wide; at step 5, `red_led` and `blue_led` low 255 of every 256 cycles, `green_led` always 1.
- STEP with B=64, step 7 -> each LED low exactly 64 of 256 cycles; with B=0, all LEDs stay 1.
- FADE with dwell=0, B=3 -> `level` per tick 0,1,2,3,3,2,1,0,0, then `step` advances; 8 ticks per step.
- NUM_STEPS=3 in STEP mode -> `step` sequence 0,1,2,0; wrap `step_pulse` present.
- Pause asserted mid-FADE for 100 cycles -> `step`/`level` unchanged and PWM duty persists; after release, the sequence continues from the same tick position.
- Behaviour across mode changes, reset and OFF/HOLD:
  - HOLD with `color_sel`=3'b010 -> only `green_led` toggles.
  - Switching to OFF -> all LEDs 1 within 2 cycles.
  - Asserting `rst` mid-step -> outputs return to their reset values asynchronously.
